// File: rtl/mod3_stream_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mod3_stream_seq                                               |
// | Function : Stream front/back-end around a combinational mod-3 reducer:   |
// |            operand FIFO, one-cycle issue, registered result stream.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mod3_stream_seq #(
    parameter int NUM_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_WIDTH-1:0] in_data,
    output logic                 mod_en,
    output logic [NUM_WIDTH-1:0] mod_num,
    input  logic [NUM_WIDTH-1:0] mod_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_WIDTH-1:0] out_data,
    output logic [NUM_WIDTH-1:0] out_operand,
    output logic [AW:0]          fifo_count,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam logic [AW:0]          C_FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [NUM_WIDTH-1:0] C_MAX_REM    = NUM_WIDTH'(2);

    state_t               r_state;
    state_t               w_next;
    logic [NUM_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic [NUM_WIDTH-1:0] r_out_data;
    logic [NUM_WIDTH-1:0] r_out_operand;
    logic                 r_err;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_WIDTH-1:0] w_head;

    assign w_full = (r_count == C_FULL_COUNT);
    assign w_push = in_valid && !w_full;
    assign w_pop  = (r_state == S_ISSUE);
    assign w_head = r_mem[r_rd_ptr];

    // Storage is not reset; clearing the pointers discards any contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // OUT decides on the pre-push count, so a same-cycle push waits for IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = (r_count != '0) ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data    <= '0;
            r_out_operand <= '0;
            r_err         <= 1'b0;
        end else if (w_pop) begin
            r_out_data    <= mod_res;
            r_out_operand <= w_head;
            if (mod_res > C_MAX_REM) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign mod_en      = (r_state == S_ISSUE);
    assign mod_num     = mod_en ? w_head : '0;
    assign out_valid   = (r_state == S_OUT);
    assign out_data    = r_out_data;
    assign out_operand = r_out_operand;
    assign fifo_count  = r_count;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mod3_stream_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mod3_stream_seq                                            |
// | Function : Scoreboard bench for mod3_stream_seq with a stub reducer.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mod3_stream_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       mod_en;
    logic [7:0] mod_num;
    logic [7:0] mod_res;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [7:0] out_operand;
    logic [2:0] fifo_count;
    logic       err;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [15:0] sb[$];
    bit          tp_chk = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_hs = 0;
    bit          sim_pend = 1'b0;
    logic [2:0]  sim_cnt = 3'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub reducer: deliberately wrong for operand 10 to exercise err.
    assign mod_res = (mod_num == 8'd10) ? 8'd5 : (mod_num % 8'd3);

    mod3_stream_seq #(.NUM_WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mod_en(mod_en), .mod_num(mod_num), .mod_res(mod_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_operand(out_operand),
        .fifo_count(fifo_count), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, idle-output rule, push+pop count, throughput.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            chk("mod_num_zero_when_idle", (!mod_en) ? mod_num : 8'd0, 8'd0);
            if (sim_pend) begin
                chk("count_push_pop", fifo_count, sim_cnt);
                sim_pend = 1'b0;
            end
            if (mod_en && in_valid && in_ready) begin
                sim_pend = 1'b1;
                sim_cnt  = fifo_count;
            end
            if (!tp_chk) have_prev = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_operand", out_operand, e[15:8]);
                    chk("out_data", out_data, e[7:0]);
                end
                if (tp_chk && have_prev) chk("throughput_gap", cyc - prev_hs, 2);
                have_prev = 1'b1;
                prev_hs   = cyc;
            end
        end else begin
            sim_pend  = 1'b0;
            have_prev = 1'b0;
        end
    end

    task automatic push(input logic [7:0] d, input logic [7:0] r);
        int  n = 0;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        if (acc) sb.push_back({d, r});
        else chk("push_timeout", 0, 1);
    endtask

    task automatic wait_empty();
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 300);
        chk("drain_timeout", (sb.size() == 0 && !out_valid) ? 1 : 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mod_en", mod_en, 0);
        chk("rst_mod_num", mod_num, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_err", err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_operand", out_operand, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single operand latency
        cycles(1);
        out_ready = 1'b1;
        push(8'd200, 8'd2);
        chk("lat_idle_count", fifo_count, 1);
        chk("lat_idle_en", mod_en, 0);
        cycles(1);
        chk("lat_issue_en", mod_en, 1);
        chk("lat_issue_num", mod_num, 200);
        cycles(1);
        chk("lat_out_valid", out_valid, 1);
        cycles(1);
        chk("lat_back_idle", out_valid, 0);
        chk("lat_count0", fifo_count, 0);
        wait_empty();

        // Burst with backpressure, then full-rate drain
        out_ready = 1'b0;
        push(8'd0, 8'd0);
        push(8'd1, 8'd1);
        push(8'd255, 8'd0);
        push(8'd96, 8'd0);
        push(8'd97, 8'd1);
        chk("burst_count_full", fifo_count, 4);
        chk("burst_in_ready", in_ready, 0);
        tp_chk    = 1'b1;
        out_ready = 1'b1;
        wait_empty();
        tp_chk = 1'b0;

        // Backpressure hold
        out_ready = 1'b0;
        push(8'd7, 8'd1);
        push(8'd9, 8'd0);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin cycles(1); n++; end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 1);
            chk("hold_operand", out_operand, 7);
            chk("hold_no_issue", mod_en, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty();

        // Fill, then push while OUT retires; pointers wrap, 11 emerges last
        out_ready = 1'b0;
        push(8'd3, 8'd0);
        push(8'd4, 8'd1);
        push(8'd5, 8'd2);
        push(8'd6, 8'd0);
        push(8'd8, 8'd2);
        chk("wrap_full", fifo_count, 4);
        out_ready = 1'b1;
        push(8'd11, 8'd2);
        chk("wrap_count_after_push", fifo_count, 4);
        wait_empty();

        // Error flag from a faulty reducer result
        chk("err_before", err, 0);
        push(8'd10, 8'd5);
        wait_empty();
        chk("err_set", err, 1);
        push(8'd4, 8'd1);
        push(8'd250, 8'd1);
        wait_empty();
        chk("err_sticky", err, 1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push(8'd20, 8'd2);
        push(8'd21, 8'd0);
        push(8'd22, 8'd1);
        push(8'd23, 8'd2);
        cycles(2);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_count", fifo_count, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_err", err, 0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycles(1);
        out_ready = 1'b1;
        push(8'd50, 8'd2);
        wait_empty();
        chk("post_rst_err", err, 0);

        cycles(3);
        chk("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1);
    end

endmodule
`default_nettype wire
